// File: rtl/cache_packet_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_packet_responder
// Description : Target-side memory responder for the unified cache packet
//               protocol. Round-robin request arbitration, block backing store,
//               read returns on the requesting way.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_packet_responder #(
    parameter int NUM_WAY                            = 2,
    parameter int NUM_ENTRY                          = 16,
    parameter int ACCESS_LATENCY                     = 4,
    parameter int CPU_ADDR_LEN_IN_BITS               = 32,
    parameter int UNIFIED_CACHE_BLOCK_SIZE_IN_BITS   = 128,
    parameter int UNIFIED_CACHE_PACKET_BYTE_MASK_LEN = 16,
    parameter int UNIFIED_CACHE_PACKET_PORT_ID_WIDTH = 2,
    parameter int UNIFIED_CACHE_PACKET_TYPE_WIDTH    = 2,
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = CPU_ADDR_LEN_IN_BITS
                                                     + UNIFIED_CACHE_BLOCK_SIZE_IN_BITS
                                                     + UNIFIED_CACHE_PACKET_TYPE_WIDTH
                                                     + UNIFIED_CACHE_PACKET_BYTE_MASK_LEN
                                                     + UNIFIED_CACHE_PACKET_PORT_ID_WIDTH + 3
) (
    input  logic                                                  clk_in,
    input  logic                                                  reset_n_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_WAY-1:0] request_packet_flatted_in,
    output logic [NUM_WAY-1:0]                                    request_packet_ack_flatted_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_WAY-1:0] return_packet_flatted_out,
    input  logic [NUM_WAY-1:0]                                    return_packet_ack_flatted_in,
    output logic                                                  busy_out,
    output logic                                                  error_out
);

    localparam int c_pkt_w   = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int c_addr_w  = CPU_ADDR_LEN_IN_BITS;
    localparam int c_blk_w   = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS;
    localparam int c_mask_w  = UNIFIED_CACHE_PACKET_BYTE_MASK_LEN;
    localparam int c_port_w  = UNIFIED_CACHE_PACKET_PORT_ID_WIDTH;
    localparam int c_type_w  = UNIFIED_CACHE_PACKET_TYPE_WIDTH;

    // Packet field positions, LSB first
    localparam int c_addr_pos      = 0;
    localparam int c_data_pos      = c_addr_pos + c_addr_w;
    localparam int c_type_pos      = c_data_pos + c_blk_w;
    localparam int c_mask_pos      = c_type_pos + c_type_w;
    localparam int c_port_pos      = c_mask_pos + c_mask_w;
    localparam int c_valid_pos     = c_port_pos + c_port_w;
    localparam int c_is_write_pos  = c_valid_pos + 1;
    localparam int c_cacheable_pos = c_valid_pos + 2;

    localparam int c_block_bytes = c_blk_w / 8;
    localparam int c_off_w       = $clog2(c_block_bytes);
    localparam int c_idx_w       = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
    localparam int c_way_w       = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
    localparam int c_lat_w       = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    function automatic logic [c_pkt_w-1:0] packet_concat(
        input logic [c_addr_w-1:0] addr,
        input logic [c_blk_w-1:0]  data,
        input logic [c_type_w-1:0] pkt_type,
        input logic [c_mask_w-1:0] mask,
        input logic [c_port_w-1:0] port_num,
        input logic                valid,
        input logic                is_write,
        input logic                cacheable
    );
        logic [c_pkt_w-1:0] pkt;
        pkt = '0;
        pkt[c_cacheable_pos:0] = {cacheable, is_write, valid, port_num, mask, pkt_type, data, addr};
        return pkt;
    endfunction

    state_t                    r_state;
    logic [c_way_w-1:0]        r_rr_ptr;
    logic [c_way_w-1:0]        r_grant_way;
    logic [c_lat_w-1:0]        r_lat_cnt;
    logic [NUM_WAY-1:0]        r_ack;
    logic [c_pkt_w*NUM_WAY-1:0] r_return_flat;
    logic                      r_error;
    logic [c_addr_w-1:0]       r_addr;
    logic [c_blk_w-1:0]        r_data;
    logic [c_type_w-1:0]       r_type;
    logic [c_mask_w-1:0]       r_mask;
    logic [c_port_w-1:0]       r_port;
    logic                      r_is_write;
    logic                      r_cacheable;
    logic [c_blk_w-1:0]        r_mem [NUM_ENTRY];

    logic                      w_hi_found;
    logic                      w_low_found;
    logic [c_way_w-1:0]        w_hi_way;
    logic [c_way_w-1:0]        w_low_way;
    logic                      w_grant_found;
    logic [c_way_w-1:0]        w_grant_way;
    logic [c_way_w-1:0]        w_next_ptr;
    logic [c_pkt_w-1:0]        w_sel_pkt;
    logic                      w_port_mismatch;
    logic [c_idx_w-1:0]        w_index;

    // Round-robin: lowest valid way at or above the pointer, else lowest valid way
    always_comb begin
        w_hi_found  = 1'b0;
        w_low_found = 1'b0;
        w_hi_way    = '0;
        w_low_way   = '0;
        for (int k = NUM_WAY - 1; k >= 0; k--) begin
            if (request_packet_flatted_in[k*c_pkt_w + c_valid_pos]) begin
                w_low_found = 1'b1;
                w_low_way   = c_way_w'(k);
                if (k >= int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_way   = c_way_w'(k);
                end
            end
        end
    end

    assign w_grant_found   = w_hi_found | w_low_found;
    assign w_grant_way     = w_hi_found ? w_hi_way : w_low_way;
    assign w_next_ptr      = (int'(w_grant_way) == NUM_WAY - 1) ? '0 : w_grant_way + 1'b1;
    assign w_sel_pkt       = request_packet_flatted_in[int'(w_grant_way)*c_pkt_w +: c_pkt_w];
    assign w_port_mismatch = int'(w_sel_pkt[c_port_pos +: c_port_w]) != int'(w_grant_way);
    assign w_index         = r_addr[c_off_w +: c_idx_w];

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_way   <= '0;
            r_lat_cnt     <= '0;
            r_ack         <= '0;
            r_return_flat <= '0;
            r_error       <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_type        <= '0;
            r_mask        <= '0;
            r_port        <= '0;
            r_is_write    <= 1'b0;
            r_cacheable   <= 1'b0;
            for (int e = 0; e < NUM_ENTRY; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_ack[w_grant_way] <= 1'b1;
                        r_grant_way        <= w_grant_way;
                        r_rr_ptr           <= w_next_ptr;
                        r_addr             <= w_sel_pkt[c_addr_pos +: c_addr_w];
                        r_data             <= w_sel_pkt[c_data_pos +: c_blk_w];
                        r_type             <= w_sel_pkt[c_type_pos +: c_type_w];
                        r_mask             <= w_sel_pkt[c_mask_pos +: c_mask_w];
                        r_port             <= w_sel_pkt[c_port_pos +: c_port_w];
                        r_is_write         <= w_sel_pkt[c_is_write_pos];
                        r_cacheable        <= w_sel_pkt[c_cacheable_pos];
                        r_lat_cnt          <= c_lat_w'(ACCESS_LATENCY - 1);
                        if (w_port_mismatch) begin
                            r_error <= 1'b1;
                        end
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_lat_cnt == '0) begin
                        if (r_is_write) begin
                            for (int b = 0; b < c_block_bytes; b++) begin
                                if (r_mask[b]) begin
                                    r_mem[w_index][b*8 +: 8] <= r_data[b*8 +: 8];
                                end
                            end
                            r_state <= S_IDLE;
                        end else begin
                            for (int w = 0; w < NUM_WAY; w++) begin
                                r_return_flat[w*c_pkt_w +: c_pkt_w] <= (w == int'(r_grant_way)) ?
                                    packet_concat(r_addr, r_mem[w_index], r_type, '0, r_port,
                                                  1'b1, 1'b0, r_cacheable) : '0;
                            end
                            r_state <= S_RESPOND;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (return_packet_ack_flatted_in[r_grant_way]) begin
                        r_return_flat <= '0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign request_packet_ack_flatted_out = r_ack;
    assign return_packet_flatted_out      = r_return_flat;
    assign busy_out                       = (r_state != S_IDLE);
    assign error_out                      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cache_packet_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_packet_responder
// Description : Self-checking bench for cache_packet_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_packet_responder;

    localparam int NW  = 2;
    localparam int LAT = 4;
    localparam int AW  = 32;
    localparam int BW  = 128;
    localparam int MW  = 16;
    localparam int PW  = 2;
    localparam int TW  = 2;
    localparam int PKT = AW + BW + TW + MW + PW + 3;
    localparam int P_DATA  = AW;
    localparam int P_TYPE  = P_DATA + BW;
    localparam int P_MASK  = P_TYPE + TW;
    localparam int P_PORT  = P_MASK + MW;
    localparam int P_VALID = P_PORT + PW;
    localparam int P_WR    = P_VALID + 1;
    localparam int P_CA    = P_VALID + 2;

    typedef logic [PKT-1:0] pkt_t;

    typedef struct {
        int          way;
        bit          wr;
        logic [31:0] addr;
        logic [127:0] data;
        logic [15:0] mask;
        logic [1:0]  port;
        logic [127:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PKT*NW-1:0] req_flat = '0;
    logic [PKT*NW-1:0] ret_flat;
    logic [NW-1:0]     req_ack;
    logic [NW-1:0]     ret_ack = '0;
    logic              busy;
    logic              err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_way = NW - 1;
    int   e0 = 0;
    pkt_t sb_q[$];

    cache_packet_responder #(
        .NUM_WAY(NW), .NUM_ENTRY(16), .ACCESS_LATENCY(LAT)
    ) dut (
        .clk_in                         (clk),
        .reset_n_in                     (rst_n),
        .request_packet_flatted_in      (req_flat),
        .request_packet_ack_flatted_out (req_ack),
        .return_packet_flatted_out      (ret_flat),
        .return_packet_ack_flatted_in   (ret_ack),
        .busy_out                       (busy),
        .error_out                      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic pkt_t mk(input logic [AW-1:0] a, input logic [BW-1:0] d,
                                input logic [TW-1:0] t, input logic [MW-1:0] m,
                                input logic [PW-1:0] p, input logic v,
                                input logic w, input logic c);
        pkt_t r;
        r = '0;
        r[AW-1:0]      = a;
        r[P_DATA +: BW] = d;
        r[P_TYPE +: TW] = t;
        r[P_MASK +: MW] = m;
        r[P_PORT +: PW] = p;
        r[P_VALID]     = v;
        r[P_WR]        = w;
        r[P_CA]        = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request on one way, wait for its ack, drop valid on that edge
    task automatic send_req(input int way, input pkt_t p, input int exp_wait);
        int  k;
        bit  got;
        k   = 0;
        got = 0;
        req_flat[way*PKT +: PKT] = p;
        while (k < 60 && !got) begin
            @(posedge clk); #1;
            k++;
            if (req_ack[way]) got = 1;
        end
        req_flat[way*PKT +: PKT] = '0;
        chk("ack_seen", 256'(got), 256'(1));
        if (got) begin
            e0 = cyc;
            last_way = way;
            chk("ack_latency", 256'(k), 256'(exp_wait));
            chk("ack_onehot", 256'(req_ack), 256'(1) << way);
            @(posedge clk); #1;
            chk("ack_pulse_len", 256'(req_ack), 256'(0));
        end
    endtask

    // Wait for the return on a way, compare with the scoreboard, hold, then consume
    task automatic get_resp(input int way, input int hold);
        int   k;
        bit   got;
        pkt_t exp;
        k   = 0;
        got = 0;
        while (k < 60 && !got) begin
            if (ret_flat[way*PKT + P_VALID]) got = 1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("ret_seen", 256'(got), 256'(1));
        if (!got) return;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 256'(0), 256'(1));
            return;
        end
        exp = sb_q.pop_front();
        chk("ret_latency", 256'(cyc - e0), 256'(LAT));
        chk("ret_pkt", 256'(ret_flat[way*PKT +: PKT]), 256'(exp));
        for (int w = 0; w < NW; w++) begin
            if (w != way) chk("ret_other_zero", 256'(ret_flat[w*PKT +: PKT]), 256'(0));
        end
        ret_ack = ~(NW'(1) << way);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("ret_hold", 256'(ret_flat[way*PKT +: PKT]), 256'(exp));
            chk("no_grant_in_respond", 256'(req_ack), 256'(0));
        end
        ret_ack = NW'(1) << way;
        @(posedge clk); #1;
        ret_ack = '0;
        chk("ret_cleared", 256'(ret_flat), 256'(0));
        chk("idle_after_ack", 256'(busy), 256'(0));
    endtask

    task automatic wait_write_done();
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk); #1;
            chk("write_no_return", 256'(ret_flat), 256'(0));
        end
        chk("write_idle", 256'(busy), 256'(0));
    endtask

    // Both ways hold read requests; grants must alternate starting after last_way
    task automatic rr_run(input int n, input pkt_t rd0, input pkt_t rd1,
                          input pkt_t ex0, input pkt_t ex1);
        int k;
        int aw;
        req_flat[0 +: PKT]   = rd0;
        req_flat[PKT +: PKT] = rd1;
        for (int g = 0; g < n; g++) begin
            k  = 0;
            aw = -1;
            while (k < 60 && aw < 0) begin
                @(posedge clk); #1;
                k++;
                for (int w = 0; w < NW; w++) if (req_ack[w]) aw = w;
            end
            chk("rr_grant_seen", 256'(aw >= 0), 256'(1));
            if (aw < 0) break;
            chk("rr_order", 256'(aw), 256'((last_way + 1) % NW));
            last_way = aw;
            e0 = cyc;
            req_flat[aw*PKT +: PKT] = '0;
            sb_q.push_back(aw == 0 ? ex0 : ex1);
            get_resp(aw, 0);
            if (g < n - 2) req_flat[aw*PKT +: PKT] = (aw == 0) ? rd0 : rd1;
        end
        req_flat = '0;
    endtask

    vec_t tbl[10];
    pkt_t p;
    pkt_t e;
    pkt_t ex0;
    pkt_t ex1;
    int   k;
    bit   got;

    initial begin
        tbl[0] = '{0, 1, 32'h0000_1000, {32{4'hA}},  16'hFFFF, 2'd0, 128'h0};
        tbl[1] = '{1, 0, 32'h0000_1000, 128'h0,      16'h0,    2'd1, {32{4'hA}}};
        tbl[2] = '{0, 1, 32'h0000_1010, {32{4'hF}},  16'h00FF, 2'd0, 128'h0};
        tbl[3] = '{0, 0, 32'h0000_1010, 128'h0,      16'h0,    2'd0, {64'h0, {16{4'hF}}}};
        tbl[4] = '{1, 1, 32'h0000_2030, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, 2'd1, 128'h0};
        tbl[5] = '{0, 1, 32'h0000_5030, {32{4'h5}},  16'hF0F0, 2'd0, 128'h0};
        tbl[6] = '{1, 0, 32'h0000_0030, 128'h0,      16'h0,    2'd1, 128'h55555555_89ABCDEF_55555555_76543210};
        tbl[7] = '{0, 1, 32'h0000_1000, 128'h0,      16'h0000, 2'd0, 128'h0};
        tbl[8] = '{0, 0, 32'hFFF0_1000, 128'h0,      16'h0,    2'd0, {32{4'hA}}};
        tbl[9] = '{1, 0, 32'h0000_0050, 128'h0,      16'h0,    2'd1, 128'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ret", 256'(ret_flat), 256'(0));
        chk("reset_ack", 256'(req_ack), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_err", 256'(err), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            p = mk(tbl[i].addr, tbl[i].wr ? tbl[i].data : 128'h0, TW'(i),
                   tbl[i].wr ? tbl[i].mask : 16'h0, tbl[i].port, 1'b1, tbl[i].wr, (i % 2) == 1);
            if (!tbl[i].wr) begin
                sb_q.push_back(mk(tbl[i].addr, tbl[i].exp, TW'(i), 16'h0, tbl[i].port,
                                  1'b1, 1'b0, (i % 2) == 1));
            end
            send_req(tbl[i].way, p, 1);
            if (tbl[i].wr) wait_write_done();
            else get_resp(tbl[i].way, 0);
        end
        chk("err_after_table", 256'(err), 256'(0));

        // Simultaneous held reads: 0,1,0,1
        ex0 = mk(32'h0000_1010, {64'h0, {16{4'hF}}}, 2'd1, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1);
        ex1 = mk(32'h0000_1000, {32{4'hA}},          2'd2, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0);
        rr_run(4, mk(32'h0000_1010, 128'h0, 2'd1, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1),
                  mk(32'h0000_1000, 128'h0, 2'd2, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0), ex0, ex1);

        // Delayed return ack with a competing write pending on the other way
        sb_q.push_back(mk(32'h0000_1000, {32{4'hA}}, 2'd3, 16'h0, 2'd1, 1'b1, 1'b0, 1'b1));
        send_req(1, mk(32'h0000_1000, 128'h0, 2'd3, 16'h0, 2'd1, 1'b1, 1'b0, 1'b1), 1);
        req_flat[0 +: PKT] = mk(32'h0000_0070, {16{8'h77}}, 2'd0, 16'hFFFF, 2'd0, 1'b1, 1'b1, 1'b1);
        get_resp(1, 7);
        k   = 0;
        got = 0;
        while (k < 10 && !got) begin
            @(posedge clk); #1;
            k++;
            if (req_ack[0]) got = 1;
        end
        req_flat = '0;
        chk("pending_grant_after_respond", 256'(k), 256'(1));
        last_way = 0;
        wait_write_done();
        sb_q.push_back(mk(32'h0000_0070, {16{8'h77}}, 2'd0, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0));
        send_req(1, mk(32'h0000_0070, 128'h0, 2'd0, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0), 1);
        get_resp(1, 0);

        // Port number mismatch on way 1
        chk("err_before_mismatch", 256'(err), 256'(0));
        sb_q.push_back(mk(32'h0000_1000, {32{4'hA}}, 2'd1, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1));
        send_req(1, mk(32'h0000_1000, 128'h0, 2'd1, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1), 1);
        chk("err_rises", 256'(err), 256'(1));
        get_resp(1, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", 256'(err), 256'(1));

        // Reset during RESPOND
        send_req(0, mk(32'h0000_1010, 128'h0, 2'd0, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0), 1);
        k   = 0;
        got = 0;
        while (k < 20 && !got) begin
            @(posedge clk); #1;
            k++;
            if (ret_flat[P_VALID]) got = 1;
        end
        chk("respond_reached", 256'(got), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_ret", 256'(ret_flat), 256'(0));
        chk("async_reset_busy", 256'(busy), 256'(0));
        chk("async_reset_err", 256'(err), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        last_way = NW - 1;
        ex0 = mk(32'h0000_1010, 128'h0, 2'd0, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        ex1 = mk(32'h0000_1000, 128'h0, 2'd1, 16'h0, 2'd1, 1'b1, 1'b0, 1'b1);
        rr_run(2, mk(32'h0000_1010, 128'h0, 2'd0, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0),
                  mk(32'h0000_1000, 128'h0, 2'd1, 16'h0, 2'd1, 1'b1, 1'b0, 1'b1), ex0, ex1);
        chk("sb_drained", 256'(sb_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
